// File: rtl/instruction_set_pkg.sv
// Instruction word field definitions shared by the fetch unit and its consumers.
//   INSTR_W          instruction word width
//   OPCODE_MSB/LSB   opcode field position inside the word
//   FUNC_MSB/LSB     function field position inside the word
//   PC_STEP          byte distance between sequential instructions
package instruction_set_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNC_MSB   = 5;
    localparam int unsigned FUNC_LSB   = 0;
    localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int unsigned FUNC_W     = FUNC_MSB - FUNC_LSB + 1;
    localparam int unsigned PC_STEP    = 4;

    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [FUNC_W-1:0]   func_t;

endpackage

// File: rtl/ifetch_buffer.sv
// Small synchronous FIFO with flush, used for both the fetched-word buffer and the
// in-flight PC tag queue.
//   i_flush      empties the FIFO; a push in the same cycle is dropped
//   i_push       write i_push_data (accepted when not full, or when full and popping)
//   i_pop        remove the head entry (ignored when empty)
//   o_rd_data    head entry
//   o_empty      no entries
//   o_count      number of entries (0..DEPTH)
module ifetch_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order reads to instruction memory,
// buffers returned words and hands them to the decoder over valid/ready. A redirect
// flushes the buffer and drops every response still owed by memory.
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr/gnt          request channel (addr = PC, stable while req && !gnt)
//   imem_rvalid/rdata          in-order response channel
//   redirect_valid/pc          taken branch/jump, highest priority
//   if_valid/ready             instruction handshake towards the decoder
//   if_instr/if_pc/opcode/func head instruction, its address and decoded fields
// Optional feature macro IFETCH_PERF_CNT_EN adds saturating stall_cnt and flush_cnt outputs.
module instruction_fetch
    import instruction_set_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output opcode_t            opcode,
    output func_t              func
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned DISC_W = 16;
    localparam int unsigned ENT_W  = INSTR_W + ADDR_W;

    logic [ADDR_W-1:0] r_pc;
    logic [DISC_W-1:0] r_discard;

    logic [CNT_W-1:0]  w_buf_count;
    logic [CNT_W-1:0]  w_tag_count;
    logic              w_buf_empty;
    logic              w_tag_empty;
    logic [ADDR_W-1:0] w_tag_head;
    logic [ENT_W-1:0]  w_buf_head;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [SUM_W-1:0]  w_used;
    logic              w_pop;
    logic              w_fire;
    logic              w_drop;
    logic              w_take;
    logic              w_push;
    logic              w_retire;

    assign w_redirect_pc = redirect_pc & ~ADDR_W'(PC_STEP - 1);

    // Credit counts buffered words plus live in-flight requests. The slot freed by a
    // pop this cycle is reusable immediately, which is what lets a 2-entry buffer
    // sustain one instruction per cycle against a 1-cycle memory.
    assign w_pop  = if_valid && if_ready;
    assign w_used = SUM_W'(w_buf_count) + SUM_W'(w_tag_count) - SUM_W'(w_pop);

    assign imem_req  = rst_n && (w_used < SUM_W'(DEPTH)) && !redirect_valid;
    assign imem_addr = r_pc;
    assign w_fire    = imem_req && imem_gnt;

    // Responses owed to flushed requests come back first and are dropped.
    assign w_drop   = imem_rvalid && (r_discard != '0);
    assign w_take   = imem_rvalid && (r_discard == '0) && !w_tag_empty;
    assign w_push   = w_take && !redirect_valid;
    assign w_retire = w_drop || w_take;

    // PC and discard bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_discard <= '0;
        end else if (redirect_valid) begin
            r_pc      <= w_redirect_pc;
            // Everything still owed becomes discard; a response arriving now retires one.
            r_discard <= r_discard + DISC_W'(w_tag_count) + DISC_W'(imem_gnt)
                         - DISC_W'(w_retire);
        end else begin
            if (w_fire) begin
                r_pc <= r_pc + ADDR_W'(PC_STEP);
            end
            if (w_drop) begin
                r_discard <= r_discard - DISC_W'(1);
            end
        end
    end

    // PC of every live in-flight request, in issue order.
    ifetch_buffer #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid),
        .i_push      (w_fire),
        .i_push_data (r_pc),
        .i_pop       (w_take),
        .o_rd_data   (w_tag_head),
        .o_empty     (w_tag_empty),
        .o_count     (w_tag_count)
    );

    // Returned words paired with their PC, waiting for the decoder.
    ifetch_buffer #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data ({imem_rdata, w_tag_head}),
        .i_pop       (w_pop),
        .o_rd_data   (w_buf_head),
        .o_empty     (w_buf_empty),
        .o_count     (w_buf_count)
    );

    assign if_valid = !w_buf_empty;
    assign if_instr = w_buf_head[ADDR_W +: INSTR_W];
    assign if_pc    = w_buf_head[ADDR_W-1:0];
    assign opcode   = if_instr[OPCODE_MSB:OPCODE_LSB];
    assign func     = if_instr[FUNC_MSB:FUNC_LSB];

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (if_ready && !if_valid && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (redirect_valid && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a queue-based memory model plus a program-order model of
// what the decoder must see (sequential PCs, restarted at every redirect).
module tb_instruction_fetch;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [5:0]  opcode;
    logic [5:0]  func;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    instruction_fetch #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .opcode         (opcode),
        .func           (func)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t        mq[$];
    logic [31:0] ga[$];
    int          n_checks, n_fail;
    int          cyc, live;
    int          n_grant, n_pop, n_stall, n_redir;
    logic [31:0] exp_fetch, exp_pc;
    bit          prev_stall, prev_redir;
    logic [31:0] prev_pc, prev_instr;
    bit          last_pop, last_req, last_valid, last_rvalid;
    logic [31:0] last_addr, last_pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2], a[25:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, advance past the edge.
    task automatic step(input bit rdy, input bit g, input bit redir,
                        input logic [31:0] rpc, input int lat);
        bit          pop_now;
        bit          exp_req;
        logic [31:0] ew;
        logic [31:0] tgt;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if_ready       = rdy;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        imem_gnt = g & imem_req;
        #1;
        if (prev_stall) begin
            check("hold_valid", 64'(if_valid), 64'd1);
            check("hold_pc", 64'(if_pc), 64'(prev_pc));
            check("hold_instr", 64'(if_instr), 64'(prev_instr));
        end
        if (prev_redir) check("flush_valid", 64'(if_valid), 64'd0);
        pop_now = if_valid && if_ready;
        exp_req = !redir && ((live - int'(pop_now)) < int'(DEPTH));
        check("req", 64'(imem_req), 64'(exp_req));
        if (imem_req) check("req_addr", 64'(imem_addr), 64'(exp_fetch));
        last_req    = imem_req;
        last_addr   = imem_addr;
        last_valid  = if_valid;
        last_rvalid = imem_rvalid;
        last_pop    = pop_now;
        if (imem_req && imem_gnt) begin
            mq.push_back('{addr: imem_addr, due: cyc + lat});
            ga.push_back(imem_addr);
            exp_fetch = exp_fetch + 32'd4;
            live++;
            n_grant++;
        end
        if (pop_now) begin
            ew = mem_word(exp_pc);
            check("pop_pc", 64'(if_pc), 64'(exp_pc));
            check("pop_instr", 64'(if_instr), 64'(ew));
            check("pop_opcode", 64'(opcode), 64'(ew[31:26]));
            check("pop_func", 64'(func), 64'(ew[5:0]));
            last_pop_pc = if_pc;
            exp_pc = exp_pc + 32'd4;
            live--;
            n_pop++;
        end
        if (if_ready && !if_valid) n_stall++;
        if (redir) begin
            tgt       = rpc & 32'hFFFF_FFFC;
            exp_pc    = tgt;
            exp_fetch = tgt;
            live      = 0;
            n_redir++;
        end
        prev_stall = if_valid && !if_ready && !redir;
        prev_redir = redir;
        prev_pc    = if_pc;
        prev_instr = if_instr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        mq.delete();
        #1;
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'(RESET_PC));
        repeat (2) @(posedge clk);
        #1;
        exp_fetch  = RESET_PC;
        exp_pc     = RESET_PC;
        live       = 0;
        n_stall    = 0;
        n_redir    = 0;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    endtask

    task automatic perf_check();
`ifdef IFETCH_PERF_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(n_stall));
        check("flush_cnt", 64'(flush_cnt), 64'(n_redir));
`endif
    endtask

    initial begin
        int first, p0, g0, c0;
        n_checks = 0; n_fail = 0; cyc = 0;
        n_grant = 0; n_pop = 0;
        redirect_pc = '0; imem_rdata = '0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: streaming from reset, one instruction per cycle from the third cycle.
        first = -1; c0 = cyc; p0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1);
            if (last_pop && first < 0) first = cyc - 1 - c0;
        end
        check("t1_first_pop", 64'(first), 64'd2);
        check("t1_pops", 64'(n_pop - p0), 64'd18);

        // 2: consumer stalled -> only DEPTH requests, then order preserved on release.
        step(1'b0, 1'b1, 1'b1, 32'h200, 1);
        g0 = n_grant;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1);
        check("t2_grants", 64'(n_grant - g0), 64'(DEPTH));
        check("t2_req_low", 64'(last_req), 64'd0);
        p0 = n_pop;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("t2_pops", 64'(n_pop - p0), 64'd10);

        // 3: reset mid-stream, then grant withheld with request pending at 0x8.
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1);
            check("t3_req", 64'(last_req), 64'd1);
            check("t3_addr", 64'(last_addr), 64'h8);
        end
        ga.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("t3_ngrant", 64'(ga.size() >= 2), 64'd1);
        if (ga.size() >= 2) begin
            check("t3_ga0", 64'(ga[0]), 64'h8);
            check("t3_ga1", 64'(ga[1]), 64'hC);
        end

        // 4: two requests in flight flushed by a redirect to an unaligned target.
        drain(6);
        step(1'b1, 1'b1, 1'b1, 32'h10, 3);
        ga.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 3);
        check("t4_inflight", 64'(ga.size()), 64'd2);
        step(1'b1, 1'b1, 1'b1, 32'h103, 3);
        first = -1; last_pop_pc = '0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 3);
            if (last_pop && first < 0) begin
                first = i;
                check("t4_pc", 64'(last_pop_pc), 64'h100);
            end
            if (i < 4) check("t4_valid_low", 64'(last_valid), 64'd0);
        end
        check("t4_first_pop", 64'(first), 64'd4);

        // 5: redirect coinciding with a response and a pop.
        drain(6);
        step(1'b0, 1'b1, 1'b1, 32'h300, 1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1);
        step(1'b1, 1'b1, 1'b1, 32'h400, 1);
        check("t5_pop", 64'(last_pop), 64'd1);
        check("t5_pop_pc", 64'(last_pop_pc), 64'h300);
        check("t5_rvalid", 64'(last_rvalid), 64'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("t5_empty", 64'(last_valid), 64'd0);
        first = -1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1);
            if (last_pop && first < 0) begin
                first = i;
                check("t5_next_pc", 64'(last_pop_pc), 64'h400);
            end
        end
        check("t5_resumed", 64'(first >= 0), 64'd1);

        // 6: PC wrap at the top of the address space.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1);
        ga.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("t6_ngrant", 64'(ga.size() >= 2), 64'd1);
        if (ga.size() >= 2) begin
            check("t6_ga0", 64'(ga[0]), 64'hFFFF_FFFC);
            check("t6_ga1", 64'(ga[1]), 64'h0);
        end
        perf_check();

        // Random traffic: ready, grant, latency and redirects all randomised.
        p0 = n_pop;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0, $urandom, $urandom_range(1, 4));
        end
        drain(8);
        check("rand_progress", 64'((n_pop - p0) > 50), 64'd1);
        perf_check();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
